qmac_seq: RTL and testbench
===========================

QMAC_SEQ -- requirements
Module: qmac_seq

Interface
REQ-001 Parameter N, default 16, total fixed-point width (signed two's complement).
REQ-002 Parameter Q, default 12, fractional bits (Q3.12 at defaults).
REQ-003 Parameter LEN_W, default 8, width of vector-length input.
REQ-004 Parameter GUARD, default 4, extra accumulator integer bits.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request a new dot product; sampled only in IDLE.
REQ-008 len  input  LEN_W  number of element pairs; captured with start.
REQ-009 a_data  input  N  operand A element.
REQ-010 b_data  input  N  operand B element.
REQ-011 in_valid  input  1  a_data/b_data valid.
REQ-012 in_ready  output  1  block accepts an element pair this cycle.
REQ-013 result  output  N  saturated dot product, Q format.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 ovf  output  1  overflow flag for the current/last result.

Function
REQ-018 Products SHALL come from one instance of the team's qmult (same N, Q), shared across all elements of a vector.
REQ-019 States SHALL be IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: start=1 captures len, clears accumulator, product register and ovf; goes to RUN if len!=0, else DONE with result 0.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 RUN: in_ready=1; a handshake (in_valid&in_ready) registers the qmult product and its overflow bit, and decrements the remaining count.
REQ-023 A registered product SHALL be added to the accumulator in the cycle after its handshake (one-stage pipeline); back-to-back handshakes sustain one pair per cycle.
REQ-024 On the len-th handshake the FSM SHALL go to DRAIN; in_ready SHALL be 0 from the next cycle.
REQ-025 DRAIN SHALL last exactly one cycle, adding the final product, then go to DONE.
REQ-026 Accumulator SHALL be N+GUARD bits signed; products are sign-extended before add; accumulator wrap is not permitted at len<=2^GUARD.
REQ-027 In DONE, result SHALL be the accumulator saturated to N bits: >max gives 2^(N-1)-1, <min gives -2^(N-1).
REQ-028 ovf SHALL be set if any qmult overflow bit was registered or final saturation occurred; sticky until next accepted start.
REQ-029 DONE: out_valid=1, result and ovf stable until out_valid&out_ready, then IDLE in the next cycle.
REQ-030 out_valid SHALL rise exactly 2 cycles after the last input handshake.
REQ-031 in_valid while not RUN SHALL have no effect.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, in_ready=0, out_valid=0, busy=0, ovf=0, result=0, accumulator/count/product=0, including mid-operation.
REQ-033 After rst_n release, the first start SHALL be accepted on the first rising edge.

Verification
REQ-034 len=3, A={0x1000,0x0800,0xF000}, B={0x2000,0x2000,0x0800} back-to-back -> result 0x2800 (2.5), ovf=0, out_valid 2 cycles after 3rd handshake.
REQ-035 len=4, A=B=0x1800 each -> accumulated 9.0 saturates, result 0x7FFF, ovf=1; same with A=0xE800 -> result 0x8000, ovf=1.
REQ-036 len=0 start -> DONE next cycle, result 0x0000, ovf=0, no in_ready pulse.
REQ-037 len=2 with in_valid gaps and out_ready held low 5 cycles -> result held stable, busy=1 until handshake, IDLE the cycle after.
REQ-038 A=B=0x7000 (qmult overflow), len=1 -> ovf=1; following start clears ovf.
REQ-039 rst_n asserted in RUN after 1 of 3 pairs -> all outputs 0 asynchronously; fresh len=1 run 0x1000*0x1000 -> 0x1000.

Source files
------------

// File: rtl/qmac_seq.sv
// Sequential Q-format dot-product engine: one shared saturating multiplier feeding
// a guarded accumulator, with a saturated result held until the consumer takes it.

module qmult #(
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  output logic signed [N-1:0] p_o,
  output logic                ovf_o
);
  localparam int W2 = 2 * N;
  localparam logic signed [W2-1:0] P_MAX = {{(N + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [W2-1:0] P_MIN = {{(N + 1){1'b1}}, {(N - 1){1'b0}}};

  logic signed [W2-1:0] full_s;
  logic signed [W2-1:0] shr_s;

  assign full_s = W2'(a_i) * W2'(b_i);
  assign shr_s  = full_s >>> Q;

  // Truncating rescale back to Q fractional bits, clamped to the N-bit range.
  always_comb begin
    p_o   = shr_s[N-1:0];
    ovf_o = 1'b0;
    if (shr_s > P_MAX) begin
      p_o   = P_MAX[N-1:0];
      ovf_o = 1'b1;
    end else if (shr_s < P_MIN) begin
      p_o   = P_MIN[N-1:0];
      ovf_o = 1'b1;
    end else begin
      ovf_o = 1'b0;
    end
  end
endmodule

module qmac_seq #(
  parameter int N     = 16,
  parameter int Q     = 12,
  parameter int LEN_W = 8,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [N-1:0]     a_data,
  input  logic [N-1:0]     b_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);
  localparam int AW = N + GUARD;
  localparam logic signed [AW-1:0] ACC_MAX = {{(GUARD + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {{(GUARD + 1){1'b1}}, {(N - 1){1'b0}}};
  localparam logic [LEN_W-1:0]     CNT_ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic signed [N-1:0] prod_q, prod_d;
  logic                pend_q, pend_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [N-1:0]        result_q, result_d;

  logic signed [N-1:0]  qp_s;
  logic                 qovf_s;
  logic                 hs_s;
  logic signed [AW-1:0] acc_sum_s;
  logic [N:0]           sat_s;

  // Returns {saturated, value}: accumulator clamped to the N-bit output range.
  function automatic logic [N:0] sat_acc(input logic signed [AW-1:0] v);
    if (v > ACC_MAX) begin
      return {1'b1, ACC_MAX[N-1:0]};
    end else if (v < ACC_MIN) begin
      return {1'b1, ACC_MIN[N-1:0]};
    end else begin
      return {1'b0, v[N-1:0]};
    end
  endfunction

  qmult #(.N(N), .Q(Q)) u_qmult (
    .a_i  (a_data),
    .b_i  (b_data),
    .p_o  (qp_s),
    .ovf_o(qovf_s)
  );

  assign hs_s      = in_valid && (state_q == S_RUN);
  assign acc_sum_s = acc_q + AW'(prod_q);
  assign sat_s     = sat_acc(acc_sum_s);

  assign in_ready  = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign ovf       = ovf_q;
  assign result    = result_q;

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    pend_d   = pend_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d    = len;
          prod_d   = '0;
          pend_d   = 1'b0;
          acc_d    = '0;
          ovf_d    = 1'b0;
          result_d = '0;
          state_d  = (len != '0) ? S_RUN : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Product registered last cycle is folded in now; a new one may land alongside.
        if (pend_q) begin
          acc_d = acc_sum_s;
        end else begin
          acc_d = acc_q;
        end
        pend_d = hs_s;
        if (hs_s) begin
          prod_d = qp_s;
          ovf_d  = ovf_q | qovf_s;
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        acc_d    = acc_sum_s;
        pend_d   = 1'b0;
        result_d = sat_s[N-1:0];
        ovf_d    = ovf_q | sat_s[N];
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      pend_q   <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      pend_q   <= pend_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_qmac_seq.sv
// Scoreboard bench for qmac_seq: the driver queues expected {ovf,result} from a
// plain-arithmetic dot-product model; an independent monitor checks each delivered result.

module tb_qmac_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [15:0] a_data = 16'd0;
  logic [15:0] b_data = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        ovf;

  int          total = 0;
  int          bad = 0;
  logic [16:0] expq[$];
  int          va[16];
  int          vb[16];
  int          ready_mode = 0;

  qmac_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .a_data   (a_data),
    .b_data   (b_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .result   (result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Dot product of the first n pairs in va/vb, Q3.12 real-number semantics with clamping.
  function automatic logic [16:0] ref_dot(input int n);
    longint acc = 0;
    longint p;
    bit     o = 1'b0;
    logic [15:0] r;
    for (int i = 0; i < n; i++) begin
      p = (longint'(va[i]) * longint'(vb[i])) >>> 12;
      if (p > 32767) begin p = 32767; o = 1'b1; end
      else if (p < -32768) begin p = -32768; o = 1'b1; end
      acc += p;
    end
    if (acc > 32767) begin acc = 32767; o = 1'b1; end
    else if (acc < -32768) begin acc = -32768; o = 1'b1; end
    r = acc[15:0];
    return {o, r};
  endfunction

  task automatic set_pair(input int i, input logic [15:0] a, input logic [15:0] b);
    va[i] = int'(signed'(a));
    vb[i] = int'(signed'(b));
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_pair(input int a, input int b);
    bit hs = 1'b0;
    int n = 0;
    a_data   = a[15:0];
    b_data   = b[15:0];
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 100);
    if (!hs) chk("handshake_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic run_body(input int n, input int gapmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapmax)) begin
        in_valid = 1'b0;
        start    = 1'($urandom_range(0, 1));
        len      = 8'($urandom);
        @(posedge clk); #1;
      end
      send_pair(va[i], vb[i]);
    end
    start    = 1'b0;
    in_valid = 1'b1;
    a_data   = 16'($urandom);
    b_data   = 16'($urandom);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("done_latency", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int n, input int gapmax);
    wait_idle();
    expq.push_back(ref_dot(n));
    start    = 1'b1;
    len      = n[7:0];
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      chk("len0_out_valid", {31'd0, out_valid}, 32'd1);
      chk("len0_in_ready", {31'd0, in_ready}, 32'd0);
    end else begin
      chk("start_clears_ovf", {31'd0, ovf}, 32'd0);
      chk("run_in_ready", {31'd0, in_ready}, 32'd1);
      run_body(n, gapmax);
    end
  endtask

  // out_ready generator: random, forced low, or forced high.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: out_ready = 1'b0;
        2: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare every accepted result against the scoreboard and check hold stability.
  initial begin
    logic [16:0] prev = 17'd0;
    logic [16:0] e;
    bit have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !out_valid) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev) chk("hold_stable", {15'd0, ovf, result}, {15'd0, prev});
        if (out_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            chk("result", {15'd0, ovf, result}, {15'd0, e});
          end
          have_prev = 1'b0;
        end else begin
          prev = {ovf, result};
          have_prev = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    int b;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_pair(0, 16'h1000, 16'h2000);
    set_pair(1, 16'h0800, 16'h2000);
    set_pair(2, 16'hF000, 16'h0800);
    run_vec(3, 0);

    for (int i = 0; i < 4; i++) set_pair(i, 16'h1800, 16'h1800);
    run_vec(4, 0);
    for (int i = 0; i < 4; i++) set_pair(i, 16'hE800, 16'h1800);
    run_vec(4, 0);

    run_vec(0, 0);

    wait_idle();
    ready_mode = 1;
    set_pair(0, 16'h0C00, 16'hF400);
    set_pair(1, 16'h2000, 16'h0400);
    run_vec(2, 3);
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    ready_mode = 2;
    b = 0;
    while (out_valid && b < 20) begin
      @(posedge clk); #1;
      b++;
    end
    chk("release_idle", {31'd0, busy}, 32'd0);
    ready_mode = 0;

    set_pair(0, 16'h7000, 16'h7000);
    run_vec(1, 0);
    set_pair(0, 16'h0400, 16'h0400);
    run_vec(1, 0);

    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        if (t % 2 == 0) set_pair(i, 16'($urandom_range(0, 16'h4000) - 16'h2000),
                                    16'($urandom_range(0, 16'h4000) - 16'h2000));
        else set_pair(i, 16'($urandom), 16'($urandom));
      end
      run_vec(n, (t % 3 == 0) ? 0 : 2);
    end

    wait_idle();
    set_pair(0, 16'h1000, 16'h2000);
    start = 1'b1;
    len   = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    send_pair(va[0], vb[0]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    set_pair(0, 16'h1000, 16'h1000);
    expq.push_back(ref_dot(1));
    start = 1'b1;
    len   = 8'd1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_start_after_rst", {31'd0, in_ready}, 32'd1);
    run_body(1, 0);

    b = 0;
    while (expq.size() != 0 && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    chk("queue_drained", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
